// File: rtl/i2cs_pkg.sv
// rtl/i2cs_pkg.sv - shared constants for the I2C slave input conditioner
// Purpose: counter width, idle line level and default synchroniser depth.
package i2cs_pkg;

  localparam int                    I2CS_LEN_W       = 8;
  localparam logic                  I2CS_IDLE_LVL    = 1'b1;
  localparam int                    I2CS_SYNC_STAGES = 2;
  localparam logic [I2CS_LEN_W-1:0] I2CS_CNT_ZERO    = '0;
  localparam logic [I2CS_LEN_W-1:0] I2CS_CNT_ONE     = I2CS_LEN_W'(1);

endpackage

// File: rtl/i2cs_line_filter.sv
// rtl/i2cs_line_filter.sv - synchroniser, debounce and delay for one I2C line
// Purpose: turns one raw asynchronous pin into a clean, delayed level.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_line              raw pin
//   i_enabled           low forces debounce/delay state to idle
//   i_debounce_len      debounce length N (glitches of <= N cycles rejected)
//   i_delay_len         delay length D
//   o_line              conditioned level (registered)
//   o_line_next         value o_line takes at the next clock edge
module i2cs_line_filter
  import i2cs_pkg::*;
#(
  parameter int SYNC_STAGES = I2CS_SYNC_STAGES
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_line,
  input  logic                  i_enabled,
  input  logic [I2CS_LEN_W-1:0] i_debounce_len,
  input  logic [I2CS_LEN_W-1:0] i_delay_len,
  output logic                  o_line,
  output logic                  o_line_next
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [I2CS_LEN_W-1:0]  r_cnt;
  logic                   r_out;
  logic [I2CS_LEN_W-1:0]  r_dcnt;

  logic                   w_synced;
  logic                   w_stable_next;
  logic [I2CS_LEN_W-1:0]  w_cnt_next;
  logic                   w_out_next;
  logic [I2CS_LEN_W-1:0]  w_dcnt_next;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // The synchroniser keeps running while disabled so re-enable sees the
  // current pin level without a metastability window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{I2CS_IDLE_LVL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
    end
  end

  // Debounce: a new level must differ for N+1 consecutive cycles. The >=
  // compare lets a live reduction of N finish on the next cycle.
  always_comb begin
    w_stable_next = r_stable;
    w_cnt_next    = r_cnt;
    if (!i_enabled) begin
      w_stable_next = I2CS_IDLE_LVL;
      w_cnt_next    = I2CS_CNT_ZERO;
    end else if (w_synced == r_stable) begin
      w_cnt_next    = I2CS_CNT_ZERO;
    end else if (r_cnt >= i_debounce_len) begin
      w_stable_next = w_synced;
      w_cnt_next    = I2CS_CNT_ZERO;
    end else begin
      w_cnt_next    = r_cnt + I2CS_CNT_ONE;
    end
  end

  // Delay: one pending change; if stable reverts before expiry the change
  // is dropped, so out never pulses.
  always_comb begin
    w_out_next  = r_out;
    w_dcnt_next = r_dcnt;
    if (!i_enabled) begin
      w_out_next  = I2CS_IDLE_LVL;
      w_dcnt_next = I2CS_CNT_ZERO;
    end else if (r_stable == r_out) begin
      w_dcnt_next = I2CS_CNT_ZERO;
    end else if (r_dcnt >= i_delay_len) begin
      w_out_next  = r_stable;
      w_dcnt_next = I2CS_CNT_ZERO;
    end else begin
      w_dcnt_next = r_dcnt + I2CS_CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= I2CS_IDLE_LVL;
      r_cnt    <= I2CS_CNT_ZERO;
      r_out    <= I2CS_IDLE_LVL;
      r_dcnt   <= I2CS_CNT_ZERO;
    end else begin
      r_stable <= w_stable_next;
      r_cnt    <= w_cnt_next;
      r_out    <= w_out_next;
      r_dcnt   <= w_dcnt_next;
    end
  end

  assign o_line      = r_out;
  assign o_line_next = w_out_next;

endmodule

// File: rtl/i2cs_input_conditioner.sv
// rtl/i2cs_input_conditioner.sv - I2C slave pin conditioning and bus condition detect
// Purpose: conditions SCL/SDA and reports SCL edges, START, STOP and bus busy.
// Ports:
//   apb_pclk_i, apb_presetn_i        clock, asynchronous active-low reset
//   i2c_scl_i, i2c_sda_i             raw pins
//   i2c_enabled_i                    low forces idle outputs
//   i2c_debounce_len_i               debounce length, both lines
//   i2c_scl_delay_len_i / _sda_      per-line delay lengths
//   scl_o, sda_o                     conditioned levels
//   scl_rise_o, scl_fall_o           SCL edge strobes
//   start_o, stop_o                  bus condition strobes
//   bus_busy_o                       high between START and STOP
module i2cs_input_conditioner
  import i2cs_pkg::*;
#(
  parameter int SYNC_STAGES = I2CS_SYNC_STAGES
) (
  input  logic                  apb_pclk_i,
  input  logic                  apb_presetn_i,
  input  logic                  i2c_scl_i,
  input  logic                  i2c_sda_i,
  input  logic                  i2c_enabled_i,
  input  logic [I2CS_LEN_W-1:0] i2c_debounce_len_i,
  input  logic [I2CS_LEN_W-1:0] i2c_scl_delay_len_i,
  input  logic [I2CS_LEN_W-1:0] i2c_sda_delay_len_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic                  scl_rise_o,
  output logic                  scl_fall_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  bus_busy_o
);

  logic w_scl;
  logic w_scl_next;
  logic w_sda;
  logic w_sda_next;

  logic r_scl_rise;
  logic r_scl_fall;
  logic r_start;
  logic r_stop;
  logic r_busy;

  i2cs_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_scl_filter (
    .i_clk          (apb_pclk_i),
    .i_rst_n        (apb_presetn_i),
    .i_line         (i2c_scl_i),
    .i_enabled      (i2c_enabled_i),
    .i_debounce_len (i2c_debounce_len_i),
    .i_delay_len    (i2c_scl_delay_len_i),
    .o_line         (w_scl),
    .o_line_next    (w_scl_next)
  );

  i2cs_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sda_filter (
    .i_clk          (apb_pclk_i),
    .i_rst_n        (apb_presetn_i),
    .i_line         (i2c_sda_i),
    .i_enabled      (i2c_enabled_i),
    .i_debounce_len (i2c_debounce_len_i),
    .i_delay_len    (i2c_sda_delay_len_i),
    .o_line         (w_sda),
    .o_line_next    (w_sda_next)
  );

  // Strobes are derived from the filters' next values so they register on
  // the same edge as the level change they describe. Requiring SCL high
  // both before and after means a simultaneous SCL/SDA change only counts
  // as an SCL edge.
  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
    end else if (!i2c_enabled_i) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_scl_rise <= ~w_scl & w_scl_next;
      r_scl_fall <= w_scl & ~w_scl_next;
      r_start    <= w_scl & w_scl_next & w_sda & ~w_sda_next;
      r_stop     <= w_scl & w_scl_next & ~w_sda & w_sda_next;
      if (r_start) begin
        r_busy <= 1'b1;
      end else if (r_stop) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign scl_o      = w_scl;
  assign sda_o      = w_sda;
  assign scl_rise_o = r_scl_rise;
  assign scl_fall_o = r_scl_fall;
  assign start_o    = r_start;
  assign stop_o     = r_stop;
  assign bus_busy_o = r_busy;

endmodule

// File: doc/i2cs_input_conditioner.md
# i2cs_input_conditioner

Input conditioning stage between the raw I2C pins and the I2C peripheral interface of the I2C slave. Synchronises SCL/SDA, removes glitches with a programmable debounce, and applies programmable per-line delays for hold-time compensation. Produces clean line levels plus single-cycle SCL edge, START and STOP strobes for the downstream protocol engine. The debounce and delay lengths come from the existing peripheral register block.

## Interface
- SYNC_STAGES, 2, synchroniser flops per line (≥2)
- apb_pclk_i  in  1  system clock; single clock domain
- apb_presetn_i  in  1  reset, asynchronous, active-low
- i2c_scl_i  in  1  raw SCL pin (asynchronous)
- i2c_sda_i  in  1  raw SDA pin (asynchronous)
- i2c_enabled_i  in  1  low forces the idle outputs
- i2c_debounce_len_i  in  8  debounce length N, both lines
- i2c_scl_delay_len_i  in  8  SCL delay length Dc
- i2c_sda_delay_len_i  in  8  SDA delay length Dd
- scl_o  out  1  conditioned SCL level
- sda_o  out  1  conditioned SDA level
- scl_rise_o  out  1  1-cycle strobe when scl_o goes 0→1
- scl_fall_o  out  1  1-cycle strobe when scl_o goes 1→0
- start_o  out  1  1-cycle strobe on a START or repeated START
- stop_o  out  1  1-cycle strobe on a STOP
- bus_busy_o  out  1  high from START until STOP

## Operation
- Reset values: synchronisers=1, scl_o=1, sda_o=1, all strobes=0, bus_busy_o=0, counters=0.
- Synchroniser: SYNC_STAGES flops per line. Always runs, including when disabled.
- Debounce (per line): register `stable` and counter `cnt`.
  - Synced value == stable: cnt←0.
  - Synced value differs and cnt ≥ N: stable←synced value, cnt←0.
  - Otherwise: cnt←cnt+1.
  - A glitch of ≤N cycles is rejected; ≥N+1 cycles is accepted. N=0 gives a 1-cycle pass-through.
- Delay (per line): register `out`, counter `dcnt`, one pending target.
  - When stable ≠ out, dcnt counts.
  - When dcnt ≥ D, out←stable and dcnt←0.
  - If stable reverts to out before expiry, the pending change is cancelled and dcnt←0. out never toggles.
- Length inputs are sampled live every cycle. Using ≥ comparisons means a mid-count reduction completes on the next cycle and never hangs.
- Condition detection uses previous and current values of the delayed outputs:
  - start_o: sda 1→0 while scl was 1 and is 1.
  - stop_o: sda 0→1 while scl was 1 and is 1.
  - When scl and sda change in the same cycle, only the SCL edge strobe fires. No START or STOP is reported.
- bus_busy_o: set by start_o, cleared by stop_o. A repeated START keeps it set.
- i2c_enabled_i=0 holds these values every cycle:
  - scl_o=sda_o=1, strobes=0, bus_busy_o=0.
  - Debounce and delay registers are forced to 1 and counters to 0.
- On re-enable, a line already low at the pin produces a normal fall after the full latency. No START is reported unless SCL is high at that point.

## Timing
- Pin to output latency: SYNC_STAGES + (N+1) + (D+1) clocks. With defaults (N=D=0) this is 4 clocks.
- Strobes are registered and asserted in the same cycle that scl_o/sda_o first shows the new level.
- Skew between lines is exactly Dd−Dc cycles, which allows SDA hold compensation.
- Reset asserted mid-count returns every output to its reset value asynchronously. There is no spurious strobe on deassertion.

## Structure
- Package i2cs_pkg holds:
  - I2CS_LEN_W=8 (length and counter width)
  - I2CS_IDLE_LVL=1'b1
  - default SYNC_STAGES
- Sub-module i2cs_line_filter contains synchroniser, debounce and delay for one line. It is instantiated twice (SCL, SDA).
- The top level contains the detection logic and bus_busy_o.

## Test plan
- Reset, pins at 1 → scl_o=sda_o=1, all strobes 0, bus_busy_o=0. Release reset with SDA=0: sda_o falls after 4 clocks and start_o pulses, since SCL is high.
- N=Dc=Dd=0, SCL=1, SDA 1→0 → start_o high for exactly 1 cycle, 4 clocks later, then bus_busy_o=1. SDA 0→1 later → stop_o pulse and bus_busy_o=0.
- N=3: SCL low glitch of 3 cycles → scl_o stays 1, no strobe. Low pulse of 4 cycles → scl_fall_o and scl_rise_o, each 1 cycle, scl_o low for 4 cycles.
- N=0, Dd=5, Dc=0: SDA rises 2 cycles before SCL falls → SDA lands after the fall, so no stop_o and bus_busy_o stays set.
- Same-cycle SCL 1→0 and SDA 1→0 at the pins → scl_fall_o only, no start_o.
- i2c_enabled_i dropped while bus_busy_o=1 with SCL low → next cycle scl_o=1 and bus_busy_o=0. Async reset mid debounce count → immediate reset values, no strobe afterwards.
